// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - shared state encoding and counter-width helper for the LED status panel
package led_pkg;

    typedef enum logic [1:0] {
        ST_WAIT = 2'd0,
        ST_TEST = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    // Bits needed to hold every value from 0 up to and including terminal.
    function automatic int cnt_w(input int terminal);
        return (terminal < 1) ? 1 : $clog2(terminal + 1);
    endfunction

endpackage

// File: rtl/led_status_panel_tick_gen.sv
// rtl/led_status_panel_tick_gen.sv - enable-gated prescaler producing a registered one-cycle tick
//   clk    : clock
//   rst_n  : asynchronous active-low reset
//   enable : run the prescaler; while low the count is held at 0 and tick stays low
//   tick   : high for the cycle after the count reaches DIV-1
module tick_gen
    import led_pkg::*;
#(
    parameter int DIV = 8000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    output logic tick
);

    localparam int            CW    = cnt_w(DIV - 1);
    localparam logic [CW-1:0] C_MAX = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (!enable) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            tick <= (cnt == C_MAX);
            cnt  <= (cnt == C_MAX) ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/led_status_panel.sv
// rtl/led_status_panel.sv - power-up hold-off, lamp test and fault display for a row of channel LEDs
//   clk         : clock
//   rst_n       : asynchronous active-low reset
//   fault       : live per-channel fault flags, active-high
//   ack         : one-cycle request to clear latched faults that are no longer present
//   retest      : one-cycle request (RUN only) to rerun the lamp test
//   led         : LED drive, 1 = lamp on
//   tick        : one-cycle strobe every TICK_DIV clocks after the hold-off
//   test_active : high while in TEST
//   run         : high while in RUN
module led_status_panel
    import led_pkg::*;
#(
    parameter int              N_CH        = 10,
    parameter int              STARTUP_CYC = 1048575,
    parameter int              TICK_DIV    = 8000,
    parameter int              PHASE_TICKS = 2500,
    parameter int              NUM_PHASES  = 4,
    parameter int              BLINK_TICKS = 2500,
    parameter logic [N_CH-1:0] LATCH_MASK  = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] fault,
    input  logic            ack,
    input  logic            retest,
    output logic [N_CH-1:0] led,
    output logic            tick,
    output logic            test_active,
    output logic            run
);

    localparam int SW  = cnt_w(STARTUP_CYC);
    localparam int PTW = cnt_w(PHASE_TICKS - 1);
    localparam int PW  = cnt_w(NUM_PHASES - 1);
    localparam int BW  = cnt_w(BLINK_TICKS - 1);

    localparam logic [SW-1:0]  SC_MAX = SW'(STARTUP_CYC);
    localparam logic [PTW-1:0] PT_MAX = PTW'(PHASE_TICKS - 1);
    localparam logic [PW-1:0]  PH_MAX = PW'(NUM_PHASES - 1);
    localparam logic [BW-1:0]  BT_MAX = BW'(BLINK_TICKS - 1);

    state_t          state, state_nx;
    logic [SW-1:0]   sc, sc_nx;
    logic [PTW-1:0]  pt_cnt, pt_nx;
    logic [PW-1:0]   ph, ph_nx;
    logic [BW-1:0]   bt_cnt, bt_nx;
    logic            blink, blink_nx;
    logic [N_CH-1:0] lat, lat_nx;
    logic [N_CH-1:0] led_nx;
    logic            tick_en;
    logic            tick_i;

    assign tick_en = (state != ST_WAIT);

    tick_gen #(
        .DIV(TICK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .enable(tick_en),
        .tick  (tick_i)
    );

    assign tick        = tick_i;
    assign test_active = (state == ST_TEST);
    assign run         = (state == ST_RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_WAIT;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        sc_nx    = sc;
        pt_nx    = pt_cnt;
        ph_nx    = ph;
        bt_nx    = bt_cnt;
        blink_nx = blink;
        led_nx   = '0;

        // Latches exist only where masked in; a present fault beats a coincident ack.
        lat_nx = LATCH_MASK & (fault | (lat & ~{N_CH{ack}}));

        unique case (state)
            ST_WAIT: begin
                if (sc != SC_MAX) begin
                    sc_nx = sc + 1'b1;
                end
                if (sc_nx == SC_MAX) begin
                    state_nx = ST_TEST;
                end
            end
            ST_TEST: begin
                if (tick_i) begin
                    if (pt_cnt == PT_MAX) begin
                        pt_nx = '0;
                        if (ph == PH_MAX) begin
                            ph_nx    = '0;
                            bt_nx    = '0;
                            blink_nx = 1'b0;
                            state_nx = ST_RUN;
                        end else begin
                            ph_nx = ph + 1'b1;
                        end
                    end else begin
                        pt_nx = pt_cnt + 1'b1;
                    end
                end
            end
            ST_RUN: begin
                // Retest drops any tick of this cycle; the prescaler itself keeps running.
                if (retest) begin
                    pt_nx    = '0;
                    ph_nx    = '0;
                    state_nx = ST_TEST;
                end else if (tick_i) begin
                    if (bt_cnt == BT_MAX) begin
                        bt_nx    = '0;
                        blink_nx = ~blink;
                    end else begin
                        bt_nx = bt_cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_nx = ST_WAIT;
            end
        endcase

        // LED drive follows the state being entered so every output changes on one edge.
        unique case (state_nx)
            ST_TEST: led_nx = {N_CH{ph_nx[0]}};
            ST_RUN:  led_nx = ~(fault | lat_nx) | (lat_nx & ~fault & {N_CH{blink_nx}});
            default: led_nx = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sc     <= '0;
            pt_cnt <= '0;
            ph     <= '0;
            bt_cnt <= '0;
            blink  <= 1'b0;
            lat    <= '0;
            led    <= '0;
        end else begin
            sc     <= sc_nx;
            pt_cnt <= pt_nx;
            ph     <= ph_nx;
            bt_cnt <= bt_nx;
            blink  <= blink_nx;
            lat    <= lat_nx;
            led    <= led_nx;
        end
    end

endmodule

// File: tb/tb_led_status_panel.sv
// tb/tb_led_status_panel.sv - self-checking bench for led_status_panel
module tb_led_status_panel;

    localparam int         N  = 4;
    localparam int         SC = 15;
    localparam int         TD = 4;
    localparam int         PT = 2;
    localparam int         NP = 4;
    localparam int         BT = 2;
    localparam logic [3:0] LM = 4'b0011;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] fault = '0;
    logic       ack = 1'b0;
    logic       retest = 1'b0;
    logic [3:0] led;
    logic       tick;
    logic       test_active;
    logic       run;

    int n_pass  = 0;
    int n_total = 0;

    led_status_panel #(
        .N_CH       (N),
        .STARTUP_CYC(SC),
        .TICK_DIV   (TD),
        .PHASE_TICKS(PT),
        .NUM_PHASES (NP),
        .BLINK_TICKS(BT),
        .LATCH_MASK (LM)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fault      (fault),
        .ack        (ack),
        .retest     (retest),
        .led        (led),
        .tick       (tick),
        .test_active(test_active),
        .run        (run)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Model: c counts clock edges since reset release. Once started, the prescaler never
    // stops until reset, so tick positions are a fixed arithmetic progression.
    int         c = 0;
    int         mode = 0;      // 0 WAIT, 1 TEST, 2 RUN
    int         tcount = 0;    // ticks counted since entering the current mode
    logic [3:0] lat_m = '0;
    logic [3:0] e_led = '0;
    logic       e_tick = 1'b0;
    logic       e_test = 1'b0;
    logic       e_run = 1'b0;

    function automatic logic tick_at(input int k);
        return (k >= SC + TD) && (((k - SC - TD) % TD) == 0);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c = 0; mode = 0; tcount = 0; lat_m = '0;
            e_led = '0; e_tick = 1'b0; e_test = 1'b0; e_run = 1'b0;
        end else begin
            logic tick_prev;
            c = c + 1;
            tick_prev = tick_at(c - 1);
            lat_m = LM & (fault | (ack ? 4'b0000 : lat_m));
            case (mode)
                0: if (c >= SC) begin mode = 1; tcount = 0; end
                1: if (tick_prev) begin
                       tcount = tcount + 1;
                       if (tcount == PT * NP) begin mode = 2; tcount = 0; end
                   end
                default: if (retest) begin mode = 1; tcount = 0; end
                         else if (tick_prev) tcount = tcount + 1;
            endcase
            if (mode == 0) e_led = 4'b0000;
            else if (mode == 1) e_led = (((tcount / PT) % 2) == 1) ? 4'b1111 : 4'b0000;
            else begin
                for (int i = 0; i < N; i++) begin
                    if (fault[i]) e_led[i] = 1'b0;
                    else if (lat_m[i]) e_led[i] = (((tcount / BT) % 2) == 1);
                    else e_led[i] = 1'b1;
                end
            end
            e_tick = tick_at(c);
            e_test = (mode == 1);
            e_run  = (mode == 2);
        end
    end

    always @(negedge clk) begin
        check("led", led, e_led);
        check("tick", tick, e_tick);
        check("test_active", test_active, e_test);
        check("run", run, e_run);
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        step(3);
        rst_n = 1'b1;                                   // c = 0
        step(14); check("pre_test_active", test_active, 1'b0);
                  check("wait_led", led, 4'b0000);
        step(1);  check("enter_test", test_active, 1'b1);   // c = 15
        step(4);  check("first_tick", tick, 1'b1);          // c = 19
        step(4);  check("phase0_end_led", led, 4'b0000);    // c = 23
        step(1);  check("phase1_led", led, 4'b1111);        // c = 24
        step(23); check("run_not_yet", run, 1'b0);          // c = 47
        step(1);  check("run_at_48", run, 1'b1);            // c = 48
                  check("run_led", led, 4'b1111);
        // unlatched fault pulse on channel 2
        fault = 4'b0100;
        step(1);  fault = 4'b0000; check("pulse_ch2", led, 4'b1011);   // c = 49
        step(1);  check("pulse_ch2_gone", led, 4'b1111);               // c = 50
        // latched fault pulse on channel 0
        fault = 4'b0001;
        step(1);  fault = 4'b0000; check("lat0_off", led, 4'b1110);    // c = 51
        step(4);  check("lat0_blink_off", led, 4'b1110);               // c = 55
        step(1);  check("lat0_blink_on", led, 4'b1111);                // c = 56
        step(7);  check("lat0_on_end", led, 4'b1111);                  // c = 63
        step(1);  check("lat0_off_again", led, 4'b1110);               // c = 64
        ack = 1'b1;
        step(1);  ack = 1'b0; check("lat0_acked", led, 4'b1111);       // c = 65
        // held fault on channel 1 survives ack
        fault = 4'b0010;
        step(1);  check("lat1_held", led, 4'b1101); ack = 1'b1;        // c = 66
        step(1);  ack = 1'b0; check("lat1_ack_hold", led, 4'b1101);    // c = 67
        step(1);  fault = 4'b0000;                                     // c = 68
        step(1);  check("lat1_blink_off", led, 4'b1101);               // c = 69
        step(3);  check("lat1_blink_on", led, 4'b1111); ack = 1'b1;    // c = 72
        step(1);  ack = 1'b0;                                          // c = 73
        step(7);  check("lat1_cleared", led, 4'b1111);                 // c = 80
        // latch channel 0, then retest
        fault = 4'b0001;
        step(1);  fault = 4'b0000; check("lat0_set2", led, 4'b1110);   // c = 81
        step(1);  retest = 1'b1;                                       // c = 82
        step(1);  retest = 1'b0;                                       // c = 83
                  check("retest_test", test_active, 1'b1);
                  check("retest_led", led, 4'b0000);
        step(28); check("retest_run_not_yet", run, 1'b0);              // c = 111
        step(1);  check("retest_run", run, 1'b1);                      // c = 112
                  check("retest_lat0_off", led, 4'b1110);
        step(8);  check("retest_lat0_on", led, 4'b1111);               // c = 120
        step(8);  check("retest_lat0_off2", led, 4'b1110);             // c = 128
        // reset in the middle of TEST
        step(2);  retest = 1'b1;                                       // c = 130
        step(1);  retest = 1'b0; check("second_test", test_active, 1'b1);
        step(4);                                                       // c = 135
        #2 rst_n = 1'b0;
        #1;
        check("rst_led", led, 4'b0000);
        check("rst_tick", tick, 1'b0);
        check("rst_test_active", test_active, 1'b0);
        check("rst_run", run, 1'b0);
        step(3);
        rst_n = 1'b1;
        step(14); check("rst2_wait", test_active, 1'b0);
        step(10); check("rst2_phase1", led, 4'b1111);                  // c = 24
        step(24); check("rst2_run", run, 1'b1);                        // c = 48
                  check("rst2_lat_cleared", led, 4'b1111);
        step(4);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/led_status_panel.md
LED_STATUS_PANEL -- requirements
Module: led_status_panel

Interface
REQ-001 The block SHALL accept these parameters (name, default, meaning):
- N_CH, 10, number of channel LEDs.
- STARTUP_CYC, 1048575, power-up hold-off length in clocks.
- TICK_DIV, 8000, clocks per tick (200 us at 40 MHz).
- PHASE_TICKS, 2500, ticks per lamp-test phase.
- NUM_PHASES, 4, lamp-test phase count; must be even and at least 2.
- BLINK_TICKS, 2500, blink half-period in ticks.
- LATCH_MASK, all zeros (N_CH bits), per-channel fault latching enable.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, the single clock.
- rst_n, in, 1, asynchronous active-low reset.
- fault, in, N_CH, live fault flags, active-high, synchronous to clk.
- ack, in, 1, one-cycle latch-clear request.
- retest, in, 1, one-cycle request to rerun the lamp test.
- led, out, N_CH, LED drive; 1 = lamp on (healthy).
- tick, out, 1, one-cycle strobe every TICK_DIV clocks once the hold-off has ended.
- test_active, out, 1, high while in TEST.
- run, out, 1, high while in RUN.

Function
REQ-003 The FSM SHALL have three states, WAIT, TEST and RUN, with transitions WAIT→TEST, TEST→RUN and RUN→TEST (on retest).
REQ-004 In WAIT, a startup counter SHALL increment every clock from 0 and saturate at STARTUP_CYC.
REQ-005 On the clock where the startup counter reaches STARTUP_CYC, the FSM SHALL enter TEST.
REQ-006 The prescaler SHALL be held at 0 in WAIT, count 0 to TICK_DIV-1 in TEST and RUN, and wrap to 0 after TICK_DIV-1.
REQ-007 tick SHALL be registered and high for exactly the cycle after the prescaler equals TICK_DIV-1.
REQ-008 In TEST, a phase index p SHALL advance by one after every PHASE_TICKS ticks; led SHALL be all 0 when p is even and all 1 when p is odd.
REQ-009 When p would reach NUM_PHASES, the FSM SHALL enter RUN; the phase counters SHALL reset to 0.
REQ-010 In RUN, for each channel i, led[i] SHALL equal NOT(fault[i] OR lat[i]), except for the blink case in REQ-012.
REQ-011 lat[i] SHALL exist only where LATCH_MASK[i]=1; elsewhere it SHALL read as 0. It SHALL set on any cycle with fault[i]=1, in every state.
REQ-012 A channel with lat[i]=1 and fault[i]=0 SHALL blink: led[i] follows a shared blink phase that toggles every BLINK_TICKS ticks in RUN, starts at 0 on RUN entry, and is 0 = lamp off.
REQ-013 When ack=1, every lat[i] with fault[i]=0 on the same cycle SHALL clear; latches whose fault is still present SHALL hold. When a fault and an ack coincide, set wins.
REQ-014 In RUN, retest=1 SHALL move the FSM to TEST with p=0 and the tick counters cleared; the prescaler SHALL keep running. retest SHALL be ignored in WAIT and TEST.
REQ-015 Latency from fault/ack to led in RUN SHALL be exactly one clock; all outputs SHALL be registered.
REQ-016 led SHALL be all 0 in WAIT.
REQ-017 test_active and run SHALL be decoded from the registered state.
REQ-018 Counter widths SHALL be derived with clog2 of their terminal values; no counter may overflow under any parameter set.

Reset
REQ-019 While rst_n=0, the block SHALL force state to WAIT, every counter to 0, lat to 0, led to all 0, and tick, test_active and run to 0.
REQ-020 Reset asserted mid-TEST or mid-RUN SHALL restart the full hold-off and lamp-test sequence after release.

Structure
REQ-021 The state encoding, and a function computing counter widths, SHALL live in the shared package (led_pkg); the parameter defaults SHALL stay local to the module.
REQ-022 The tick prescaler SHALL be a sub-module named tick_gen, with a divider parameter and enable, clk, rst_n and tick ports.

Verification
Parameters for all scenarios: N_CH=4, STARTUP_CYC=15, TICK_DIV=4, PHASE_TICKS=2, NUM_PHASES=4, BLINK_TICKS=2, LATCH_MASK=4'b0011.
REQ-023 Reset release → led=0000 for 16 clocks, then the pattern 0000/1111/0000/1111 with 8 clocks per phase, then run=1 at clock 48±1.
REQ-024 In RUN, pulse fault=4'b0100 for 1 clock → led[2]=0 for exactly 1 clock, one clock late; no latch set.
REQ-025 In RUN, pulse fault[0] for 1 clock → led[0] goes off, then blinks with 8-clock off/on half-periods; ack → led[0]=1 the next clock.
REQ-026 Hold fault[1]=1 and pulse ack → lat[1] stays set and led[1]=0; release fault → blink; second ack → led[1]=1.
REQ-027 retest in RUN → test_active=1 the next clock and the full 32-clock pattern repeats; lat[0] set before retest survives and blinks after return to RUN.
REQ-028 Assert rst_n=0 mid-TEST → all outputs 0 immediately; after release the full sequence restarts from the WAIT count.
